// File: rtl/seq_datapath_pkg.sv
// Shared types and pure datapath functions for seq_datapath: command/op/shift encodings,
// FSM states, flag bit positions, and the shifter/ALU evaluated on a wide word and masked to width.
package seq_datapath_pkg;

    typedef enum logic [1:0] {CMD_MOVI = 2'b00, CMD_MOV = 2'b01, CMD_ALU = 2'b10, CMD_CMP = 2'b11} cmd_e;
    typedef enum logic [1:0] {OP_ADD = 2'b00, OP_SUB = 2'b01, OP_AND = 2'b10, OP_MVN = 2'b11} alu_op_e;
    typedef enum logic [1:0] {SH_NONE = 2'b00, SH_LSL1 = 2'b01, SH_LSR1 = 2'b10, SH_ASR1 = 2'b11} shift_e;
    typedef enum logic [1:0] {S_IDLE = 2'b00, S_LOAD = 2'b01, S_EXEC = 2'b10, S_WB = 2'b11} state_e;

    localparam int FLAG_Z = 0;
    localparam int FLAG_V = 1;
    localparam int FLAG_N = 2;

    // Functions work on a 64-bit word so one definition serves any WIDTH below 64.
    localparam int MAX_W = 64;
    typedef logic [MAX_W-1:0] word_t;

    typedef struct packed {
        word_t res;
        logic  ovf;
    } alu_out_t;

    function automatic word_t width_mask(int w);
        return ~(~word_t'(0) << w);
    endfunction

    function automatic logic msb_of(word_t x, int w);
        return |(x & (word_t'(1) << (w - 1)));
    endfunction

    function automatic word_t shift_fn(word_t v, shift_e s, int w);
        word_t m;
        word_t r;
        word_t msb;
        m   = width_mask(w);
        r   = v & m;
        msb = (r >> (w - 1)) & word_t'(1);
        case (s)
            SH_LSL1: r = (r << 1) & m;
            SH_LSR1: r = r >> 1;
            SH_ASR1: r = (r >> 1) | (msb << (w - 1));
            default: r = v & m;
        endcase
        return r;
    endfunction

    function automatic alu_out_t alu_fn(word_t a, word_t b, alu_op_e op, int w);
        alu_out_t o;
        word_t    m;
        word_t    am;
        word_t    bm;
        logic     sa;
        logic     sb;
        logic     sr;
        m     = width_mask(w);
        am    = a & m;
        bm    = b & m;
        sa    = msb_of(am, w);
        sb    = msb_of(bm, w);
        o.ovf = 1'b0;
        case (op)
            OP_ADD: begin
                o.res = (am + bm) & m;
                sr    = msb_of(o.res, w);
                o.ovf = (sa == sb) && (sr != sa);
            end
            OP_SUB: begin
                o.res = (am - bm) & m;
                sr    = msb_of(o.res, w);
                o.ovf = (sa != sb) && (sr != sa);
            end
            OP_AND:  o.res = am & bm;
            default: o.res = ~bm & m;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/seq_datapath_if.sv
// Command/status bundle between a controller (master) and seq_datapath (slave).
interface seq_datapath_if #(
    parameter int WIDTH = 16,
    parameter int NREGS = 8,
    parameter int IMM_W = 5
);
    localparam int AW = $clog2(NREGS);

    logic             start;
    logic [1:0]       cmd;
    logic [1:0]       alu_op;
    logic [1:0]       shift;
    logic [AW-1:0]    rd;
    logic [AW-1:0]    rn;
    logic [AW-1:0]    rm;
    logic             use_imm;
    logic [IMM_W-1:0] imm;
    logic             ext_we;
    logic [AW-1:0]    ext_waddr;
    logic [WIDTH-1:0] ext_wdata;
    logic [AW-1:0]    dbg_raddr;
    logic [WIDTH-1:0] dbg_rdata;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic [2:0]       flags;

    modport master (
        output start, cmd, alu_op, shift, rd, rn, rm, use_imm, imm,
               ext_we, ext_waddr, ext_wdata, dbg_raddr,
        input  dbg_rdata, busy, done, result, flags
    );

    modport slave (
        input  start, cmd, alu_op, shift, rd, rn, rm, use_imm, imm,
               ext_we, ext_waddr, ext_wdata, dbg_raddr,
        output dbg_rdata, busy, done, result, flags
    );
endinterface

// File: rtl/seq_datapath_regfile.sv
// dp_regfile: NREGS x WIDTH register file, one write port, A/B operand registers loaded
// from two read paths on load_i, plus a combinational debug read. Async active-high reset.
module dp_regfile #(
    parameter int WIDTH = 16,
    parameter int NREGS = 8,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             load_i,
    input  logic [AW-1:0]    rn_i,
    input  logic [AW-1:0]    rm_i,
    output logic [WIDTH-1:0] a_o,
    output logic [WIDTH-1:0] b_o,
    input  logic [AW-1:0]    dbg_raddr_i,
    output logic [WIDTH-1:0] dbg_rdata_o
);
    logic [WIDTH-1:0] regs_q [NREGS];
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else if (we_i) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q <= '0;
            b_q <= '0;
        end else if (load_i) begin
            a_q <= regs_q[rn_i];
            b_q <= regs_q[rm_i];
        end
    end

    assign a_o         = a_q;
    assign b_o         = b_q;
    assign dbg_rdata_o = regs_q[dbg_raddr_i];
endmodule

// File: rtl/seq_datapath.sv
// Self-sequencing datapath: regfile, operand regs, shifter, ALU, C reg and flags under a
// read->execute->writeback FSM. Define SEQ_DATAPATH_NV_FLAGS_EN to add N/V flags.
//
// state  | meaning
// IDLE   | waiting for start; external regfile writes allowed
// LOAD   | A <= R[rn], B <= R[rm]
// EXEC   | C and flags <= ALU(Ain, Bin)
// WB     | R[rd] <= C (not for CMP); done asserted
module seq_datapath
    import seq_datapath_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int NREGS = 8,
    parameter int IMM_W = 5
) (
    input  logic           clk,
    input  logic           reset,
    seq_datapath_if.slave  bus
);
    localparam int AW = $clog2(NREGS);

    state_e           state_q, state_d;
    cmd_e             cmd_q;
    alu_op_e          op_q;
    shift_e           shift_q;
    logic [AW-1:0]    rd_q, rn_q, rm_q;
    logic             use_imm_q;
    logic [IMM_W-1:0] imm_q;
    logic [WIDTH-1:0] a_q, b_q, c_q, c_d;
    logic             z_q, z_d;

    logic             accept;
    logic [WIDTH-1:0] a_in, b_in, b_sh, imm_sext, imm_zext;
    alu_op_e          op_in;
    word_t            b_sh_full;
    alu_out_t         alu_out;
    logic             rf_we;
    logic [AW-1:0]    rf_waddr;
    logic [WIDTH-1:0] rf_wdata;
    logic             unused_hi;

    assign accept = (state_q == S_IDLE) && bus.start;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cmd_q     <= CMD_MOVI;
            op_q      <= OP_ADD;
            shift_q   <= SH_NONE;
            rd_q      <= '0;
            rn_q      <= '0;
            rm_q      <= '0;
            use_imm_q <= 1'b0;
            imm_q     <= '0;
            c_q       <= '0;
            z_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                cmd_q     <= cmd_e'(bus.cmd);
                op_q      <= alu_op_e'(bus.alu_op);
                shift_q   <= shift_e'(bus.shift);
                rd_q      <= bus.rd;
                rn_q      <= bus.rn;
                rm_q      <= bus.rm;
                use_imm_q <= bus.use_imm;
                imm_q     <= bus.imm;
            end
            if (state_q == S_EXEC) begin
                c_q <= c_d;
                z_q <= z_d;
            end
        end
    end

    // MOVI needs no register operands, so it skips LOAD.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (bus.start) state_d = (cmd_e'(bus.cmd) == CMD_MOVI) ? S_EXEC : S_LOAD;
            S_LOAD: state_d = S_EXEC;
            S_EXEC: state_d = S_WB;
            S_WB:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign imm_sext  = {{(WIDTH-IMM_W){imm_q[IMM_W-1]}}, imm_q};
    assign imm_zext  = {{(WIDTH-IMM_W){1'b0}}, imm_q};
    assign b_sh_full = shift_fn(word_t'(b_q), shift_q, WIDTH);
    assign b_sh      = b_sh_full[WIDTH-1:0];

    always_comb begin
        a_in  = '0;
        b_in  = '0;
        op_in = OP_ADD;
        case (cmd_q)
            CMD_MOVI: b_in = imm_sext;
            CMD_MOV:  b_in = b_sh;
            CMD_ALU: begin
                a_in  = a_q;
                b_in  = use_imm_q ? imm_zext : b_sh;
                op_in = op_q;
            end
            default: begin
                a_in  = a_q;
                b_in  = use_imm_q ? imm_zext : b_sh;
                op_in = OP_SUB;
            end
        endcase
    end

    assign alu_out   = alu_fn(word_t'(a_in), word_t'(b_in), op_in, WIDTH);
    assign c_d       = alu_out.res[WIDTH-1:0];
    assign z_d       = (c_d == '0);
    assign unused_hi = ^{alu_out.res[MAX_W-1:WIDTH], b_sh_full[MAX_W-1:WIDTH], alu_out.ovf};

`ifdef SEQ_DATAPATH_NV_FLAGS_EN
    logic n_q, v_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            n_q <= 1'b0;
            v_q <= 1'b0;
        end else if (state_q == S_EXEC) begin
            n_q <= c_d[WIDTH-1];
            v_q <= alu_out.ovf;
        end
    end

    always_comb begin
        bus.flags         = '0;
        bus.flags[FLAG_N] = n_q;
        bus.flags[FLAG_V] = v_q;
        bus.flags[FLAG_Z] = z_q;
    end
`else
    always_comb begin
        bus.flags         = '0;
        bus.flags[FLAG_Z] = z_q;
    end
`endif

    // External writes only land while IDLE, so they never collide with writeback.
    assign rf_we    = ((state_q == S_WB) && (cmd_q != CMD_CMP)) || ((state_q == S_IDLE) && bus.ext_we);
    assign rf_waddr = (state_q == S_WB) ? rd_q : bus.ext_waddr;
    assign rf_wdata = (state_q == S_WB) ? c_q : bus.ext_wdata;

    dp_regfile #(.WIDTH(WIDTH), .NREGS(NREGS)) u_regfile (
        .clk         (clk),
        .reset       (reset),
        .we_i        (rf_we),
        .waddr_i     (rf_waddr),
        .wdata_i     (rf_wdata),
        .load_i      (state_q == S_LOAD),
        .rn_i        (rn_q),
        .rm_i        (rm_q),
        .a_o         (a_q),
        .b_o         (b_q),
        .dbg_raddr_i (bus.dbg_raddr),
        .dbg_rdata_o (bus.dbg_rdata)
    );

    assign bus.busy   = (state_q != S_IDLE);
    assign bus.done   = (state_q == S_WB);
    assign bus.result = c_q;
endmodule
